store_write_buffer: RTL
=======================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered store entries; legal values are 2, 4 and 8.
REQ-002 Clock  input  1  Single clock; all state updates on the rising edge.
REQ-003 Resetn  input  1  Reset, asynchronous and active-low.
REQ-004 st_valid  input  1  Store request from the MEM stage.
REQ-005 st_addr  input  32  Store byte address; bits [1:0] are ignored (word stores only).
REQ-006 st_data  input  32  Store data word.
REQ-007 st_ready  output  1  Buffer can accept a store this cycle.
REQ-008 ld_valid  input  1  Load lookup from the MEM stage.
REQ-009 ld_addr  input  32  Load byte address; bits [1:0] are ignored.
REQ-010 ld_hit  output  1  Lookup matched a buffered store and data is forwarded.
REQ-011 ld_data  output  32  Forwarded data word.
REQ-012 ld_stall  output  1  Load must wait because a matching store is pending and cannot be forwarded.
REQ-013 mem_req  output  1  Write request to data memory.
REQ-014 mem_addr  output  32  Write address, taken from the head entry.
REQ-015 mem_data  output  32  Write data, taken from the head entry.
REQ-016 mem_ack  input  1  Data memory accepts the head write this cycle.
REQ-017 empty  output  1  No entries are buffered.
REQ-018 count  output  4  Number of valid entries, 0..DEPTH.

Function
REQ-019 The buffer SHALL be a circular FIFO with head/tail pointers of width log2(DEPTH) that wrap modulo DEPTH.
REQ-020 st_ready SHALL equal (count < DEPTH); a pop in the same cycle SHALL NOT make st_ready high when the buffer is full.
REQ-021 Push: when st_valid and st_ready are both high, {st_addr[31:2], st_data} SHALL be written at the tail, and the entry SHALL be visible on the next cycle.
REQ-022 A push attempted while st_ready is low SHALL be dropped without any state change; the upstream stage holds the request.
REQ-023 mem_req SHALL equal !empty, and mem_addr SHALL equal {head_addr, 2'b00}; mem_addr and mem_data SHALL be held stable until the cycle in which mem_ack is seen.
REQ-024 Pop: when mem_req and mem_ack are both high, the head entry SHALL be retired; mem_ack received while empty SHALL be ignored.
REQ-025 When a push and a pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 Entries SHALL drain strictly in arrival order, and no stores SHALL be merged.
REQ-027 The load lookup SHALL be combinational and SHALL compare ld_addr[31:2] against all valid entries only; a store being pushed in the same cycle SHALL NOT match.
REQ-028 When several entries match, the youngest entry SHALL win.
REQ-029 The head entry being popped in the current cycle SHALL still match in that cycle.
REQ-030 When ld_valid is low, ld_hit and ld_stall SHALL be 0 and ld_data SHALL be 0.

Reset
REQ-031 Resetn low SHALL asynchronously clear the pointers and count to 0 and invalidate all entries.
REQ-032 While in reset, mem_req, ld_hit and ld_stall SHALL be 0 and empty SHALL be 1.
REQ-033 Entry data storage SHALL NOT require a reset.
REQ-034 Reset asserted mid-transfer SHALL discard all pending stores, including an unacknowledged head; mem_ack arriving during reset SHALL be ignored.
REQ-035 After Resetn is released, operation SHALL resume on the first rising edge.

Configuration
REQ-036 Macro SWB_FORWARD_EN defined: on a match, ld_hit=1 and ld_data=the youngest matching data, and ld_stall SHALL be constant 0.
REQ-037 Macro SWB_FORWARD_EN undefined: ld_hit and ld_data SHALL be constant 0, ld_stall=ld_valid & (any match), and no forwarding mux SHALL be synthesised.

Verification
REQ-038 Reset, then push (0x100, 0xAAAA0001) with mem_ack=0: next cycle count=1, mem_req=1, mem_addr=0x100, mem_data=0xAAAA0001; mem_ack=1 for one cycle -> count=0, empty=1.
REQ-039 Fill to 4 entries with mem_ack=0: st_ready=0; push of a 5th store with st_valid=1 is dropped, count stays 4; after 4 acks the entries drain in arrival order.
REQ-040 Push (0x200, 0x11) then (0x200, 0x22); load at 0x203: with SWB_FORWARD_EN, ld_hit=1 and ld_data=0x22; without it, ld_stall=1 and ld_hit=0.
REQ-041 count=2 with a push and an ack in the same cycle: count stays 2; repeat across 10 cycles to exercise pointer wrap with no data corruption.
REQ-042 Assert Resetn=0 mid-cycle while count=3 and mem_req=1: mem_req drops immediately, count=0; after release, a new push drains normally.
REQ-043 Load at 0x300 in the same cycle as a push to 0x300 with the buffer empty: ld_hit=0 and ld_stall=0.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Store write buffer bus: store push, load lookup, memory drain and status.
// Pure wiring, no state; all timing is owned by store_write_buffer.
// Push backpressure is st_ready; the memory side drains through mem_req/mem_ack.
interface store_write_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        empty;
  logic [3:0]  count;

  // Upstream MEM stage plus data memory: drives requests, observes the buffer.
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, ld_stall, mem_req, mem_addr, mem_data, empty, count
  );

  // The buffer itself.
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, ld_stall, mem_req, mem_addr, mem_data, empty, count
  );
endinterface

// File: rtl/store_write_buffer.sv
// In-order store write buffer with combinational load lookup; SWB_FORWARD_EN selects forward vs stall on a match.
// Latency: pushed store visible (lookup and mem_req) one cycle after acceptance; lookup is zero-cycle.
// Backpressure: st_ready = count < DEPTH (a same-cycle pop never frees a full buffer); head holds until mem_ack.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic               i_clock,
  input logic               i_resetn,
  store_write_buffer_if.slave bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [3:0]      C_DEPTH = 4'(DEPTH);
  localparam logic [PW-1:0]   C_ONE   = PW'(1);

  logic [29:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [3:0]       r_count;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;
  logic             w_any_match;
  logic             w_unused;

  // Ready depends only on the registered count so a pop never unblocks a full buffer combinationally.
  assign bus.st_ready = (r_count < C_DEPTH);
  assign w_push       = bus.st_valid && bus.st_ready;
  assign w_pop        = (r_count != 4'd0) && bus.mem_ack;

  assign bus.empty    = (r_count == 4'd0);
  assign bus.mem_req  = (r_count != 4'd0);
  assign bus.mem_addr = {r_addr[r_head], 2'b00};
  assign bus.mem_data = r_data[r_head];
  assign bus.count    = r_count;

  // Word-aligned buffer: byte-offset bits carry no information.
  assign w_unused = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  // Pointer, occupancy and valid-bit bookkeeping; push and pop can never hit the same slot.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 4'd0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_tail        <= r_tail + C_ONE;
        r_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + C_ONE;
        r_vld[r_head] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; it is only observed through the valid bits and count.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr[31:2];
      r_data[r_tail] <= bus.st_data;
    end
  end

  // Address compare against registered valid entries only, so a same-cycle push cannot match.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_vld[i] && (r_addr[i] == bus.ld_addr[31:2]);
    end
  end

  assign w_any_match = |w_match;

`ifdef SWB_FORWARD_EN
  logic [31:0] w_fwd_data;
  logic [PW-1:0] w_idx;

  // Walk oldest to youngest from the head so the youngest matching entry overwrites earlier ones.
  always_comb begin
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (w_match[w_idx]) begin
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign bus.ld_hit   = bus.ld_valid && w_any_match;
  assign bus.ld_data  = bus.ld_valid ? w_fwd_data : 32'd0;
  assign bus.ld_stall = 1'b0;
`else
  assign bus.ld_hit   = 1'b0;
  assign bus.ld_data  = 32'd0;
  assign bus.ld_stall = bus.ld_valid && w_any_match;
`endif

endmodule
